// File: rtl/id_ex_stage_if.sv
// ID/EX stage bus: decode inputs, pipeline control, forwarding sources
// and the ALU-facing / EX-stage outputs of the ID/EX pipeline register.
interface id_ex_stage_if #(
    parameter int XLEN       = 32,
    parameter int REG_ADDR_W = 5
);
    logic                  in_valid;
    logic [XLEN-1:0]       in_pc;
    logic [REG_ADDR_W-1:0] in_rs1_addr;
    logic [REG_ADDR_W-1:0] in_rs2_addr;
    logic [XLEN-1:0]       in_rs1_val;
    logic [XLEN-1:0]       in_rs2_val;
    logic [XLEN-1:0]       in_imm;
    logic                  in_use_imm;
    logic                  in_use_pc;
    logic [3:0]            in_alu_op;
    logic [REG_ADDR_W-1:0] in_rd_addr;
    logic                  in_reg_write;
    logic                  in_mem_read;
    logic                  in_mem_write;

    logic                  stall;
    logic                  flush;

    logic [REG_ADDR_W-1:0] exmem_rd;
    logic                  exmem_reg_write;
    logic [XLEN-1:0]       exmem_result;
    logic [REG_ADDR_W-1:0] memwb_rd;
    logic                  memwb_reg_write;
    logic [XLEN-1:0]       memwb_result;

    logic                  hazard_stall;
    logic [XLEN-1:0]       alu_operand1;
    logic [XLEN-1:0]       alu_operand2;
    logic [3:0]            alu_opcode;
    logic                  out_valid;
    logic [REG_ADDR_W-1:0] out_rd_addr;
    logic                  out_reg_write;
    logic                  out_mem_read;
    logic                  out_mem_write;
    logic [XLEN-1:0]       out_store_data;

    // Environment side: drives decode, control and forwarding sources.
    modport master (
        output in_valid, in_pc, in_rs1_addr, in_rs2_addr, in_rs1_val, in_rs2_val,
               in_imm, in_use_imm, in_use_pc, in_alu_op, in_rd_addr,
               in_reg_write, in_mem_read, in_mem_write,
               stall, flush,
               exmem_rd, exmem_reg_write, exmem_result,
               memwb_rd, memwb_reg_write, memwb_result,
        input  hazard_stall, alu_operand1, alu_operand2, alu_opcode,
               out_valid, out_rd_addr, out_reg_write, out_mem_read,
               out_mem_write, out_store_data
    );

    // Pipeline-register side.
    modport slave (
        input  in_valid, in_pc, in_rs1_addr, in_rs2_addr, in_rs1_val, in_rs2_val,
               in_imm, in_use_imm, in_use_pc, in_alu_op, in_rd_addr,
               in_reg_write, in_mem_read, in_mem_write,
               stall, flush,
               exmem_rd, exmem_reg_write, exmem_result,
               memwb_rd, memwb_reg_write, memwb_result,
        output hazard_stall, alu_operand1, alu_operand2, alu_opcode,
               out_valid, out_rd_addr, out_reg_write, out_mem_read,
               out_mem_write, out_store_data
    );
endinterface

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register for the 5-stage RV32I core. Registers decoded
// fields, inserts a one-cycle bubble on load-use hazards, and resolves
// EX/MEM and MEM/WB forwarding to produce the ALU operands.
module id_ex_stage #(
    parameter int XLEN       = 32,
    parameter int REG_ADDR_W = 5
) (
    input logic           clk,
    input logic           rst,
    id_ex_stage_if.slave  bus
);

    logic                  valid_q;
    logic [XLEN-1:0]       pc_q;
    logic [REG_ADDR_W-1:0] rs1_addr_q;
    logic [REG_ADDR_W-1:0] rs2_addr_q;
    logic [XLEN-1:0]       rs1_val_q;
    logic [XLEN-1:0]       rs2_val_q;
    logic [XLEN-1:0]       imm_q;
    logic                  use_imm_q;
    logic                  use_pc_q;
    logic [3:0]            alu_op_q;
    logic [REG_ADDR_W-1:0] rd_addr_q;
    logic                  reg_write_q;
    logic                  mem_read_q;
    logic                  mem_write_q;

    logic                  hazard;
    logic [XLEN-1:0]       fwd_rs1;
    logic [XLEN-1:0]       fwd_rs2;

    // Load-use detection: a load in EX whose rd matches either decode source.
    always_comb begin
        hazard = valid_q & mem_read_q & (rd_addr_q != '0) & bus.in_valid &
                 ((rd_addr_q == bus.in_rs1_addr) | (rd_addr_q == bus.in_rs2_addr)) &
                 ~bus.stall & ~bus.flush;
    end

    // Pipeline register update: rst > flush > stall > bubble > capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q     <= 1'b0;
            pc_q        <= '0;
            rs1_addr_q  <= '0;
            rs2_addr_q  <= '0;
            rs1_val_q   <= '0;
            rs2_val_q   <= '0;
            imm_q       <= '0;
            use_imm_q   <= 1'b0;
            use_pc_q    <= 1'b0;
            alu_op_q    <= '0;
            rd_addr_q   <= '0;
            reg_write_q <= 1'b0;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
        end else if (bus.flush || (!bus.stall && hazard)) begin
            valid_q     <= 1'b0;
            reg_write_q <= 1'b0;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
        end else if (!bus.stall) begin
            valid_q     <= bus.in_valid;
            pc_q        <= bus.in_pc;
            rs1_addr_q  <= bus.in_rs1_addr;
            rs2_addr_q  <= bus.in_rs2_addr;
            rs1_val_q   <= bus.in_rs1_val;
            rs2_val_q   <= bus.in_rs2_val;
            imm_q       <= bus.in_imm;
            use_imm_q   <= bus.in_use_imm;
            use_pc_q    <= bus.in_use_pc;
            alu_op_q    <= bus.in_alu_op;
            rd_addr_q   <= bus.in_rd_addr;
            reg_write_q <= bus.in_reg_write & bus.in_valid;
            mem_read_q  <= bus.in_mem_read  & bus.in_valid;
            mem_write_q <= bus.in_mem_write & bus.in_valid;
        end
    end

    // Operand forwarding: EX/MEM beats MEM/WB, and x0 is never forwarded.
    always_comb begin
        fwd_rs1 = rs1_val_q;
        fwd_rs2 = rs2_val_q;
        if (bus.exmem_reg_write && bus.exmem_rd != '0 && bus.exmem_rd == rs1_addr_q) begin
            fwd_rs1 = bus.exmem_result;
        end else if (bus.memwb_reg_write && bus.memwb_rd != '0 && bus.memwb_rd == rs1_addr_q) begin
            fwd_rs1 = bus.memwb_result;
        end
        if (bus.exmem_reg_write && bus.exmem_rd != '0 && bus.exmem_rd == rs2_addr_q) begin
            fwd_rs2 = bus.exmem_result;
        end else if (bus.memwb_reg_write && bus.memwb_rd != '0 && bus.memwb_rd == rs2_addr_q) begin
            fwd_rs2 = bus.memwb_result;
        end
    end

    assign bus.hazard_stall   = hazard;
    assign bus.alu_operand1   = use_pc_q  ? pc_q  : fwd_rs1;
    assign bus.alu_operand2   = use_imm_q ? imm_q : fwd_rs2;
    assign bus.alu_opcode     = alu_op_q;
    assign bus.out_valid      = valid_q;
    assign bus.out_rd_addr    = rd_addr_q;
    assign bus.out_reg_write  = reg_write_q & valid_q;
    assign bus.out_mem_read   = mem_read_q  & valid_q;
    assign bus.out_mem_write  = mem_write_q & valid_q;
    assign bus.out_store_data = fwd_rs2;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: a vector table for single-cycle behaviour
// plus hand-written sequences for forwarding priority, load-use bubbles,
// stall/flush and reset in the middle of a hazard.
module tb_id_ex_stage;

    localparam logic [3:0] EXE_ADD_OP = 4'd1;
    localparam logic [3:0] EXE_SUB_OP = 4'd2;

    typedef struct packed {
        logic        in_valid;
        logic [31:0] pc;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] rs1_val;
        logic [31:0] rs2_val;
        logic [31:0] imm;
        logic        use_imm;
        logic        use_pc;
        logic [3:0]  alu_op;
        logic [4:0]  rd;
        logic        reg_write;
        logic        mem_read;
        logic        mem_write;
        logic [4:0]  exmem_rd;
        logic        exmem_we;
        logic [31:0] exmem_res;
        logic [4:0]  memwb_rd;
        logic        memwb_we;
        logic [31:0] memwb_res;
        logic [31:0] e_op1;
        logic [31:0] e_op2;
        logic [3:0]  e_opcode;
        logic        e_valid;
        logic        e_rw;
        logic        e_mr;
        logic        e_mw;
        logic [31:0] e_store;
        logic [4:0]  e_rd;
    } vec_t;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;
    vec_t vecs[$];

    id_ex_stage_if #(.XLEN(32), .REG_ADDR_W(5)) bus ();

    id_ex_stage #(.XLEN(32), .REG_ADDR_W(5)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    // Free-running clock, rising edges at 5, 15, 25, ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_idle();
        bus.in_valid = 0; bus.in_pc = 0; bus.in_rs1_addr = 0; bus.in_rs2_addr = 0;
        bus.in_rs1_val = 0; bus.in_rs2_val = 0; bus.in_imm = 0; bus.in_use_imm = 0;
        bus.in_use_pc = 0; bus.in_alu_op = 0; bus.in_rd_addr = 0; bus.in_reg_write = 0;
        bus.in_mem_read = 0; bus.in_mem_write = 0; bus.stall = 0; bus.flush = 0;
        bus.exmem_rd = 0; bus.exmem_reg_write = 0; bus.exmem_result = 0;
        bus.memwb_rd = 0; bus.memwb_reg_write = 0; bus.memwb_result = 0;
    endtask

    task automatic drive_random();
        bus.in_valid = 1'($urandom); bus.in_pc = $urandom; bus.in_rs1_addr = 5'($urandom);
        bus.in_rs2_addr = 5'($urandom); bus.in_rs1_val = $urandom; bus.in_rs2_val = $urandom;
        bus.in_imm = $urandom; bus.in_use_imm = 1'($urandom); bus.in_use_pc = 1'($urandom);
        bus.in_alu_op = 4'($urandom); bus.in_rd_addr = 5'($urandom);
        bus.in_reg_write = 1'($urandom); bus.in_mem_read = 1'($urandom);
        bus.in_mem_write = 1'($urandom);
        bus.exmem_rd = 5'($urandom); bus.exmem_reg_write = 1'($urandom); bus.exmem_result = $urandom;
        bus.memwb_rd = 5'($urandom); bus.memwb_reg_write = 1'($urandom); bus.memwb_result = $urandom;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, " hazard_stall"},   32'(bus.hazard_stall),   0);
        check({tag, " alu_operand1"},   bus.alu_operand1,        0);
        check({tag, " alu_operand2"},   bus.alu_operand2,        0);
        check({tag, " alu_opcode"},     32'(bus.alu_opcode),     0);
        check({tag, " out_valid"},      32'(bus.out_valid),      0);
        check({tag, " out_rd_addr"},    32'(bus.out_rd_addr),    0);
        check({tag, " out_reg_write"},  32'(bus.out_reg_write),  0);
        check({tag, " out_mem_read"},   32'(bus.out_mem_read),   0);
        check({tag, " out_mem_write"},  32'(bus.out_mem_write),  0);
        check({tag, " out_store_data"}, bus.out_store_data,      0);
    endtask

    task automatic applyStimulus(input vec_t v);
        bus.in_valid = v.in_valid; bus.in_pc = v.pc; bus.in_rs1_addr = v.rs1;
        bus.in_rs2_addr = v.rs2; bus.in_rs1_val = v.rs1_val; bus.in_rs2_val = v.rs2_val;
        bus.in_imm = v.imm; bus.in_use_imm = v.use_imm; bus.in_use_pc = v.use_pc;
        bus.in_alu_op = v.alu_op; bus.in_rd_addr = v.rd; bus.in_reg_write = v.reg_write;
        bus.in_mem_read = v.mem_read; bus.in_mem_write = v.mem_write;
        bus.stall = 0; bus.flush = 0;
        bus.exmem_rd = v.exmem_rd; bus.exmem_reg_write = v.exmem_we; bus.exmem_result = v.exmem_res;
        bus.memwb_rd = v.memwb_rd; bus.memwb_reg_write = v.memwb_we; bus.memwb_result = v.memwb_res;
    endtask

    task automatic checkOutput(input int idx, input vec_t v);
        string t;
        t = $sformatf("vec%0d", idx);
        check({t, " alu_operand1"},   bus.alu_operand1,       v.e_op1);
        check({t, " alu_operand2"},   bus.alu_operand2,       v.e_op2);
        check({t, " alu_opcode"},     32'(bus.alu_opcode),    32'(v.e_opcode));
        check({t, " out_valid"},      32'(bus.out_valid),     32'(v.e_valid));
        check({t, " out_reg_write"},  32'(bus.out_reg_write), 32'(v.e_rw));
        check({t, " out_mem_read"},   32'(bus.out_mem_read),  32'(v.e_mr));
        check({t, " out_mem_write"},  32'(bus.out_mem_write), 32'(v.e_mw));
        check({t, " out_store_data"}, bus.out_store_data,     v.e_store);
        check({t, " out_rd_addr"},    32'(bus.out_rd_addr),   32'(v.e_rd));
    endtask

    // Load instruction lw x5, 4(x1) presented on the decode inputs.
    task automatic drive_load_x5();
        drive_idle();
        bus.in_valid = 1; bus.in_rs1_addr = 1; bus.in_rs1_val = 32'h100; bus.in_imm = 4;
        bus.in_use_imm = 1; bus.in_alu_op = EXE_ADD_OP; bus.in_rd_addr = 5;
        bus.in_reg_write = 1; bus.in_mem_read = 1;
    endtask

    // add x6, x1, x5 presented on the decode inputs (rs2 read data is stale).
    task automatic drive_add_uses_x5();
        drive_idle();
        bus.in_valid = 1; bus.in_rs1_addr = 1; bus.in_rs1_val = 3; bus.in_rs2_addr = 5;
        bus.in_rs2_val = 0; bus.in_alu_op = EXE_ADD_OP; bus.in_rd_addr = 6; bus.in_reg_write = 1;
    endtask

    initial begin
        vec_t v;
        n_checks = 0;
        n_fail   = 0;

        // Build the vector table.
        v = '0; v.in_valid = 1; v.rs1 = 1; v.rs2 = 2; v.rs1_val = 5; v.rs2_val = 7;
        v.alu_op = EXE_ADD_OP; v.rd = 3; v.reg_write = 1;
        v.e_op1 = 5; v.e_op2 = 7; v.e_opcode = EXE_ADD_OP; v.e_valid = 1; v.e_rw = 1;
        v.e_store = 7; v.e_rd = 3;
        vecs.push_back(v);

        v = '0; v.in_valid = 1; v.rs1 = 1; v.rs1_val = 32'h10; v.rs2_val = 32'h99;
        v.imm = 32'hFFFF_FFFC; v.use_imm = 1; v.alu_op = EXE_ADD_OP; v.rd = 6; v.reg_write = 1;
        v.e_op1 = 32'h10; v.e_op2 = 32'hFFFF_FFFC; v.e_opcode = EXE_ADD_OP; v.e_valid = 1;
        v.e_rw = 1; v.e_store = 32'h99; v.e_rd = 6;
        vecs.push_back(v);

        v = '0; v.in_valid = 1; v.pc = 32'h1000; v.use_pc = 1; v.imm = 32'h5000; v.use_imm = 1;
        v.alu_op = EXE_ADD_OP; v.rd = 7; v.reg_write = 1;
        v.e_op1 = 32'h1000; v.e_op2 = 32'h5000; v.e_opcode = EXE_ADD_OP; v.e_valid = 1;
        v.e_rw = 1; v.e_store = 0; v.e_rd = 7;
        vecs.push_back(v);

        v = '0; v.in_valid = 1; v.rs1 = 2; v.rs2 = 9; v.rs1_val = 32'h200; v.rs2_val = 32'h1234;
        v.imm = 8; v.use_imm = 1; v.alu_op = EXE_ADD_OP; v.mem_write = 1;
        v.exmem_rd = 9; v.exmem_we = 1; v.exmem_res = 32'hCAFE;
        v.e_op1 = 32'h200; v.e_op2 = 8; v.e_opcode = EXE_ADD_OP; v.e_valid = 1; v.e_mw = 1;
        v.e_store = 32'hCAFE; v.e_rd = 0;
        vecs.push_back(v);

        v = '0; v.in_valid = 0; v.rs1 = 1; v.rs2 = 2; v.rs1_val = 32'h42; v.rs2_val = 32'h43;
        v.alu_op = 4'd3; v.rd = 4; v.reg_write = 1; v.mem_read = 1; v.mem_write = 1;
        v.e_op1 = 32'h42; v.e_op2 = 32'h43; v.e_opcode = 4'd3; v.e_valid = 0;
        v.e_store = 32'h43; v.e_rd = 4;
        vecs.push_back(v);

        v = '0; v.in_valid = 1; v.rs1 = 10; v.rs2 = 11; v.rs1_val = 1; v.rs2_val = 2;
        v.alu_op = EXE_SUB_OP; v.rd = 12; v.reg_write = 1;
        v.memwb_rd = 11; v.memwb_we = 1; v.memwb_res = 32'h77;
        v.e_op1 = 1; v.e_op2 = 32'h77; v.e_opcode = EXE_SUB_OP; v.e_valid = 1; v.e_rw = 1;
        v.e_store = 32'h77; v.e_rd = 12;
        vecs.push_back(v);

        // Reset held two cycles under random inputs.
        drive_idle();
        rst = 1;
        drive_random();
        tick();
        drive_random();
        tick();
        check_all_zero("reset");
        rst = 0;

        // Table-driven single-instruction vectors.
        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i]);
            tick();
            checkOutput(i, vecs[i]);
        end

        // Forwarding priority on rs1 = x4.
        drive_idle();
        bus.in_valid = 1; bus.in_rs1_addr = 4; bus.in_rs1_val = 1; bus.in_alu_op = EXE_ADD_OP;
        bus.in_rd_addr = 8; bus.in_reg_write = 1;
        bus.exmem_rd = 4; bus.exmem_reg_write = 1; bus.exmem_result = 32'hAA;
        bus.memwb_rd = 4; bus.memwb_reg_write = 1; bus.memwb_result = 32'hBB;
        tick();
        bus.in_valid = 0;
        check("fwd exmem wins", bus.alu_operand1, 32'hAA);
        bus.exmem_reg_write = 0;
        #1 check("fwd memwb fallback", bus.alu_operand1, 32'hBB);
        bus.exmem_rd = 0; bus.exmem_reg_write = 1;
        #1 check("fwd exmem x0 ignored", bus.alu_operand1, 32'hBB);
        bus.memwb_reg_write = 0;
        #1 check("fwd none regval", bus.alu_operand1, 32'h1);

        // Load-use: one bubble, then the dependent ADD picks up load data from EX/MEM.
        drive_load_x5();
        tick();
        drive_add_uses_x5();
        #1 check("loaduse hazard_stall", 32'(bus.hazard_stall), 1);
        tick();
        check("bubble out_valid",      32'(bus.out_valid),     0);
        check("bubble out_reg_write",  32'(bus.out_reg_write), 0);
        check("bubble out_mem_read",   32'(bus.out_mem_read),  0);
        check("bubble out_mem_write",  32'(bus.out_mem_write), 0);
        check("bubble hazard cleared", 32'(bus.hazard_stall),  0);
        bus.exmem_rd = 5; bus.exmem_reg_write = 1; bus.exmem_result = 32'hDEAD;
        tick();
        check("post-bubble out_valid", 32'(bus.out_valid),    1);
        check("post-bubble operand1",  bus.alu_operand1,      3);
        check("post-bubble operand2",  bus.alu_operand2,      32'hDEAD);
        check("post-bubble hazard",    32'(bus.hazard_stall), 0);

        // Stall holds a load in EX while inputs change; hazard masked by stall.
        drive_idle();
        bus.in_valid = 1; bus.in_rs1_addr = 2; bus.in_rs1_val = 32'h11; bus.in_rs2_addr = 3;
        bus.in_rs2_val = 32'h22; bus.in_alu_op = EXE_SUB_OP; bus.in_rd_addr = 9;
        bus.in_reg_write = 1; bus.in_mem_read = 1;
        tick();
        bus.stall = 1;
        bus.in_rs1_addr = 9; bus.in_rs1_val = 32'h55; bus.in_rs2_addr = 13; bus.in_rs2_val = 32'h66;
        bus.in_alu_op = 4'd7; bus.in_rd_addr = 12; bus.in_mem_read = 0; bus.in_mem_write = 1;
        #1 check("stall masks hazard", 32'(bus.hazard_stall), 0);
        for (int c = 0; c < 3; c++) begin
            tick();
            check($sformatf("stall%0d operand1", c), bus.alu_operand1, 32'h11);
            check($sformatf("stall%0d operand2", c), bus.alu_operand2, 32'h22);
            check($sformatf("stall%0d opcode", c), 32'(bus.alu_opcode), 32'(EXE_SUB_OP));
            check($sformatf("stall%0d out_valid", c), 32'(bus.out_valid), 1);
            check($sformatf("stall%0d out_rd_addr", c), 32'(bus.out_rd_addr), 9);
            check($sformatf("stall%0d out_mem_read", c), 32'(bus.out_mem_read), 1);
        end
        bus.flush = 1;
        tick();
        check("flush out_valid",     32'(bus.out_valid),     0);
        check("flush out_reg_write", 32'(bus.out_reg_write), 0);
        check("flush out_mem_read",  32'(bus.out_mem_read),  0);

        // Reset arriving while a load-use hazard is pending.
        drive_load_x5();
        tick();
        drive_add_uses_x5();
        #1 check("midreset hazard before", 32'(bus.hazard_stall), 1);
        rst = 1;
        tick();
        check_all_zero("midreset");
        rst = 0;
        drive_idle();
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- ID/EX pipeline register for the 5-stage RV32I core; sits directly upstream of the ALU.
- Captures decoded instruction fields each cycle.
- Detects load-use hazards and inserts bubbles.
- Resolves EX/MEM and MEM/WB operand forwarding, then drives the ALU's operand1, operand2 and opcode inputs.

Parameters:
XLEN, 32, datapath width
REG_ADDR_W, 5, register index width

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  reset, synchronous, active-high
in_valid  input  1  decode slot holds a real instruction
in_pc  input  XLEN  instruction PC
in_rs1_addr  input  REG_ADDR_W  source register 1 index
in_rs2_addr  input  REG_ADDR_W  source register 2 index
in_rs1_val  input  XLEN  register-file read data for rs1
in_rs2_val  input  XLEN  register-file read data for rs2
in_imm  input  XLEN  sign-extended immediate
in_use_imm  input  1  operand2 = immediate
in_use_pc  input  1  operand1 = PC (AUIPC/JAL)
in_alu_op  input  4  EXE_*_OP code from const.v
in_rd_addr  input  REG_ADDR_W  destination register index
in_reg_write  input  1  instruction writes rd
in_mem_read  input  1  instruction is a load
in_mem_write  input  1  instruction is a store
stall  input  1  downstream hold; freeze this stage
flush  input  1  branch/jump redirect; kill this stage
exmem_rd  input  REG_ADDR_W  rd of instruction in MEM
exmem_reg_write  input  1  MEM-stage instruction writes rd
exmem_result  input  XLEN  MEM-stage ALU result
memwb_rd  input  REG_ADDR_W  rd of instruction in WB
memwb_reg_write  input  1  WB-stage instruction writes rd
memwb_result  input  XLEN  WB-stage writeback data
hazard_stall  output  1  load-use detected; upstream must hold PC and IF/ID
alu_operand1  output  XLEN  to ALU operand1
alu_operand2  output  XLEN  to ALU operand2
alu_opcode  output  4  to ALU opcode
out_valid  output  1  EX slot holds a real instruction
out_rd_addr  output  REG_ADDR_W  registered rd
out_reg_write  output  1  registered reg_write, gated by out_valid
out_mem_read  output  1  registered mem_read, gated by out_valid
out_mem_write  output  1  registered mem_write, gated by out_valid
out_store_data  output  XLEN  forwarded rs2 value for stores

Behaviour:
- Reset: every registered field cleared to 0, including valid, control bits, pc, imm and rs values. alu_opcode therefore resets to 0. All outputs are 0 the cycle after rst is sampled high. A mid-operation reset discards the held instruction.
- Register update priority per edge: rst > flush > stall > load-use bubble > capture.
  - flush: valid and all control bits cleared. Data fields are don't-care. Flush wins over stall and hazard.
  - stall (no flush): all registers hold. hazard_stall is forced to 0 while stall is high.
  - bubble: when hazard_stall=1, valid and control bits are cleared. Upstream holds, so the instruction is re-presented next cycle.
  - capture: all in_* values registered. Control bits are ANDed with in_valid.
- hazard_stall (combinational) = out_valid & out_mem_read & out_rd_addr!=0 & in_valid & (out_rd_addr==in_rs1_addr | out_rd_addr==in_rs2_addr) & ~stall & ~flush.
  - The comparison is conservative: both sources are always compared, even if unused.
  - The bubble lasts exactly 1 cycle, because the load then moves to MEM and is forwarded from there.
- Forwarding (combinational, from registered rs addresses/values):
  - fwd_rsN = exmem_result if exmem_reg_write & exmem_rd!=0 & exmem_rd==rsN_addr.
  - Else memwb_result if memwb_reg_write & memwb_rd!=0 & memwb_rd==rsN_addr.
  - Else the registered rsN_val.
  - EX/MEM has priority over MEM/WB. x0 is never forwarded.
- alu_operand1 = use_pc ? pc : fwd_rs1. alu_operand2 = use_imm ? imm : fwd_rs2. out_store_data = fwd_rs2.
- Operands are not gated by valid; consumers must qualify with out_valid.
- Latency: an instruction captured at edge N drives the ALU during cycle N, with the result consumed at edge N+1.
- The register file is write-first. A WB write in the same cycle as decode read is not this block's concern.

Test Plan:
- Reset: hold rst 2 cycles with random inputs -> all outputs 0 and hazard_stall=0. Release, present ADD x3=x1+x2 (x1=5, x2=7, EXE_ADD_OP) -> next cycle alu_operand1=5, alu_operand2=7, alu_opcode=EXE_ADD_OP, out_valid=1.
- Forwarding priority: EX holds rs1=x4 with reg_value 1. Set exmem_rd=4/exmem_result=0xAA and memwb_rd=4/memwb_result=0xBB, both write-enabled -> alu_operand1=0xAA. Drop exmem_reg_write -> 0xBB. Set exmem_rd=0 with exmem_reg_write=1 -> not forwarded.
- Load-use: LW x5 captured. Next decode is ADD rs2=x5 -> hazard_stall=1 for exactly 1 cycle, and the following cycle has out_valid=0 with all control bits 0. The ADD is then captured, and exmem forwarding supplies the load data.
- Stall/flush: with stall=1, change all inputs -> outputs unchanged for 3 cycles. Assert stall=1 and flush=1 together -> next cycle out_valid=0 and out_reg_write=0.
- Immediate/PC select: ADDI with use_imm=1, imm=0xFFFFFFFC, rs1=0x10 -> operand2=0xFFFFFFFC. AUIPC with use_pc=1, pc=0x1000 -> operand1=0x1000.
- Mid-operation reset: assert rst while hazard_stall=1 and stall=0 -> next cycle all outputs 0 and hazard_stall=0.
